// File: rtl/exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit_pkg
// Description : Op codes, FSM state type and width defaults for exec_unit.
// Revision    : 1.0
// ============================================================================
package exec_unit_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_N  = 32;
    localparam int DEF_ADDR_W = $clog2(DEF_REG_N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_SRL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_unit_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier, one multiplier bit per step.
// Revision    : 1.0
// ============================================================================
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_multiplicand,
    input  logic [DATA_W-1:0] i_multiplier,
    input  logic              i_step,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Result includes the final step so the caller can register it on the same edge.
    assign o_done   = i_step && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_result = w_acc_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= o_done ? '0 : (r_cnt + 1'b1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit
// Description : Execute/writeback stage: single-cycle ALU plus iterative MUL.
// Revision    : 1.0
// ============================================================================
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_N  = DEF_REG_N,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic [ADDR_W-1:0] i_rd,
    output logic              o_wb_en,
    output logic [ADDR_W-1:0] o_wb_reg,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_illegal,
    output logic              o_busy
);

    localparam int SH_W = $clog2(DATA_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_mul_rd;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_step;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_result;
    logic [DATA_W-1:0] w_alu_result;
    logic [SH_W-1:0]   w_shamt;
    logic              w_lt;

    assign o_ready     = (r_state == ST_IDLE);
    assign w_accept    = i_valid && o_ready;
    assign w_mul_start = w_accept && (i_op == OP_MUL);
    assign w_mul_step  = (r_state == ST_MUL);
    assign w_shamt     = i_rs2_data[SH_W-1:0];
    assign w_lt        = $signed(i_rs1_data) < $signed(i_rs2_data);

    always_comb begin
        w_alu_result = '0;
        case (i_op)
            OP_ADD:  w_alu_result = i_rs1_data + i_rs2_data;
            OP_SUB:  w_alu_result = i_rs1_data - i_rs2_data;
            OP_AND:  w_alu_result = i_rs1_data & i_rs2_data;
            OP_OR:   w_alu_result = i_rs1_data | i_rs2_data;
            OP_XOR:  w_alu_result = i_rs1_data ^ i_rs2_data;
            OP_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_SLL:  w_alu_result = i_rs1_data << w_shamt;
            OP_SRL:  w_alu_result = i_rs1_data >> w_shamt;
            default: w_alu_result = '0;
        endcase
    end

    mul_iter #(
        .DATA_W(DATA_W)
    ) u_mul_iter (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (w_mul_start),
        .i_multiplicand (i_rs1_data),
        .i_multiplier   (i_rs2_data),
        .i_step         (w_mul_step),
        .o_done         (w_mul_done),
        .o_result       (w_mul_result)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_mul_rd  <= '0;
            o_wb_en   <= 1'b0;
            o_wb_reg  <= '0;
            o_wb_data <= '0;
            o_illegal <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_wb_en   <= 1'b0;
            o_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_alu_op(i_op)) begin
                            // Register 0 is hard zero: index/data still track, strobe does not.
                            o_wb_en   <= (i_rd != '0);
                            o_wb_reg  <= i_rd;
                            o_wb_data <= w_alu_result;
                        end else if (i_op == OP_MUL) begin
                            r_state  <= ST_MUL;
                            r_mul_rd <= i_rd;
                            o_busy   <= 1'b1;
                        end else begin
                            o_illegal <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state   <= ST_IDLE;
                        o_busy    <= 1'b0;
                        o_wb_en   <= (r_mul_rd != '0);
                        o_wb_reg  <= r_mul_rd;
                        o_wb_data <= w_mul_result;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
